ram_port_arbiter: RTL and testbench

//  Two-requester round-robin arbiter in front of ram_Controller.
//  - Port 0: core load/store unit. Port 1: loader/debug DMA.
//  - Issues at most one RAM op per cycle and tracks in-flight reads.
//  - Routes each read result back to its issuing port.
//  - Rejects misaligned or illegal-size accesses without touching the RAM.

---
 rtl/ram_port_arbiter_if.sv | 27 ++
 rtl/ram_port_arbiter.sv | 106 ++++++++++
 tb/tb_ram_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bundle for one port of ram_port_arbiter.
// The requester holds req and its fields stable until it sees gnt.
interface ram_port_arbiter_if #(
  parameter int ADDRWIDTH = 12,
  parameter int XLEN      = 32
);
  logic                 req;
  logic                 we;
  logic [ADDRWIDTH-1:0] addr;
  logic [XLEN-1:0]      wdata;
  logic [1:0]           size;
  logic                 is_unsigned;
  logic                 gnt;
  logic                 err;
  logic                 rvalid;
  logic [XLEN-1:0]      rdata;

  modport master (
    output req, we, addr, wdata, size, is_unsigned,
    input  gnt, err, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, size, is_unsigned,
    output gnt, err, rvalid, rdata
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-port round-robin front end for the RAM controller: zero-latency grant,
// size/alignment screening, and a tag pipe that routes read data back to its port.
module ram_port_arbiter #(
  parameter  int DEPTH     = 4096,
  parameter  int XLEN      = 32,
  parameter  int READ_LAT  = 2,
  localparam int ADDRWIDTH = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_port_arbiter_if.slave    p0,
  ram_port_arbiter_if.slave    p1,
  output logic [ADDRWIDTH-1:0] ram_addr,
  output logic [XLEN-1:0]      ram_wrData,
  output logic                 ram_wrEn,
  output logic                 ram_rdEn,
  output logic                 ram_byteEn,
  output logic                 ram_halfEn,
  output logic                 ram_wordEn,
  output logic                 ram_unsignedEn,
  input  logic [XLEN-1:0]      ram_dataOut,
  input  logic                 ram_outEn,
  output logic                 proto_err
);

  localparam int CW = $clog2(READ_LAT + 1);

  logic                 rr_last;
  logic [READ_LAT-1:0]  tag_v;
  logic [READ_LAT-1:0]  tag_p;
  logic [CW-1:0]        settle;

  logic                 any_req;
  logic                 win1;
  logic                 illegal;
  logic                 legal;
  logic                 w_we;
  logic                 w_uns;
  logic [1:0]           w_size;
  logic [ADDRWIDTH-1:0] w_addr;

  // Reset gates every grant so nothing leaks out while rst_n is low.
  assign any_req = rst_n & (p0.req | p1.req);
  assign win1    = p1.req & (~p0.req | ~rr_last);

  assign w_we   = win1 ? p1.we          : p0.we;
  assign w_uns  = win1 ? p1.is_unsigned : p0.is_unsigned;
  assign w_size = win1 ? p1.size        : p0.size;
  assign w_addr = win1 ? p1.addr        : p0.addr;

  always_comb begin
    illegal = 1'b0;
    case (w_size)
      2'b01:   illegal = w_addr[0];
      2'b10:   illegal = (w_addr[1:0] != 2'b00);
      2'b11:   illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  assign legal = any_req & ~illegal;

  assign p0.gnt = any_req & ~win1;
  assign p1.gnt = any_req & win1;
  assign p0.err = any_req & ~win1 & illegal;
  assign p1.err = any_req & win1 & illegal;

  assign ram_addr       = w_addr;
  assign ram_wrData     = win1 ? p1.wdata : p0.wdata;
  assign ram_wrEn       = legal & w_we;
  assign ram_rdEn       = legal & ~w_we;
  assign ram_byteEn     = legal & (w_size == 2'b00);
  assign ram_halfEn     = legal & (w_size == 2'b01);
  assign ram_wordEn     = legal & (w_size == 2'b10);
  assign ram_unsignedEn = legal & w_uns;

  assign p0.rvalid = tag_v[READ_LAT-1] & ~tag_p[READ_LAT-1];
  assign p1.rvalid = tag_v[READ_LAT-1] & tag_p[READ_LAT-1];
  assign p0.rdata  = ram_dataOut;
  assign p1.rdata  = ram_dataOut;

  // The settle window hides controller responses still in flight across a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last   <= 1'b1;
      tag_v     <= '0;
      tag_p     <= '0;
      proto_err <= 1'b0;
      settle    <= CW'(READ_LAT);
    end else begin
      if (any_req) rr_last <= win1;
      tag_v[0] <= ram_rdEn;
      tag_p[0] <= win1;
      for (int i = 1; i < READ_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_p[i] <= tag_p[i-1];
      end
      if (settle != '0) begin
        settle <= settle - 1'b1;
      end else if (ram_outEn != tag_v[READ_LAT-1]) begin
        proto_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural RAM controller and
// a read-return scoreboard (port, data, arrival cycle).
module tb_ram_port_arbiter;
  localparam int AW = 12;
  localparam int XL = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDRWIDTH(AW), .XLEN(XL)) p0 ();
  ram_port_arbiter_if #(.ADDRWIDTH(AW), .XLEN(XL)) p1 ();

  logic [AW-1:0] ram_addr;
  logic [XL-1:0] ram_wrData;
  logic [XL-1:0] ram_dataOut;
  logic          ram_wrEn, ram_rdEn, ram_byteEn, ram_halfEn, ram_wordEn, ram_unsignedEn;
  logic          ram_outEn;
  logic          proto_err;

  ram_port_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .p0             (p0),
    .p1             (p1),
    .ram_addr       (ram_addr),
    .ram_wrData     (ram_wrData),
    .ram_wrEn       (ram_wrEn),
    .ram_rdEn       (ram_rdEn),
    .ram_byteEn     (ram_byteEn),
    .ram_halfEn     (ram_halfEn),
    .ram_wordEn     (ram_wordEn),
    .ram_unsignedEn (ram_unsignedEn),
    .ram_dataOut    (ram_dataOut),
    .ram_outEn      (ram_outEn),
    .proto_err      (proto_err)
  );

  // Behavioural controller: byte-lane memory, 2-cycle read pipe, not reset by rst_n.
  logic [7:0]    mem [0:4095];
  logic          loaded = 1'b0;
  logic [1:0]    v_d = 2'b00;
  logic [XL-1:0] d_d0 = '0;
  logic [XL-1:0] d_d1 = '0;
  logic          force_oe = 1'b0;

  function automatic logic [XL-1:0] rd_model(input int a);
    logic [7:0]  b;
    logic [15:0] h;
    b = mem[a];
    h = {mem[a+1], mem[a]};
    if (ram_byteEn) return ram_unsignedEn ? {24'h0, b} : {{24{b[7]}}, b};
    if (ram_halfEn) return ram_unsignedEn ? {16'h0, h} : {{16{h[15]}}, h};
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      {mem['h013], mem['h012], mem['h011], mem['h010]} <= 32'h12345678;
      {mem['h023], mem['h022], mem['h021], mem['h020]} <= 32'hCAFEF00D;
      {mem['h027], mem['h026], mem['h025], mem['h024]} <= 32'h0BADBEEF;
      loaded <= 1'b1;
    end else if (ram_wrEn) begin
      mem[int'(ram_addr)] <= ram_wrData[7:0];
      if (ram_halfEn || ram_wordEn) mem[int'(ram_addr)+1] <= ram_wrData[15:8];
      if (ram_wordEn) begin
        mem[int'(ram_addr)+2] <= ram_wrData[23:16];
        mem[int'(ram_addr)+3] <= ram_wrData[31:24];
      end
    end
    v_d  <= {v_d[0], ram_rdEn};
    d_d0 <= rd_model(int'(ram_addr));
    d_d1 <= d_d0;
  end

  assign ram_outEn   = v_d[1] | force_oe;
  assign ram_dataOut = d_d1;

  typedef struct {
    logic          port;
    logic [XL-1:0] data;
    int            due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (p0.rvalid || p1.rvalid) begin
      if (sb.size() == 0) begin
        chk("stray_rvalid", {62'h0, p1.rvalid, p0.rvalid}, 64'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("rvalid_port", {62'h0, p1.rvalid, p0.rvalid}, mon_e.port ? 64'h2 : 64'h1);
        chk("rdata", mon_e.port ? 64'(p1.rdata) : 64'(p0.rdata), 64'(mon_e.data));
        chk("read_latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit port, input bit we, input logic [AW-1:0] a,
                       input logic [XL-1:0] wd, input logic [1:0] sz, input bit uns);
    if (port) begin
      p1.req = 1'b1; p1.we = we; p1.addr = a; p1.wdata = wd; p1.size = sz; p1.is_unsigned = uns;
    end else begin
      p0.req = 1'b1; p0.we = we; p0.addr = a; p0.wdata = wd; p0.size = sz; p0.is_unsigned = uns;
    end
  endtask

  task automatic drop(input bit port);
    if (port) p1.req = 1'b0;
    else      p0.req = 1'b0;
  endtask

  // Called at the negedge of the grant cycle; a legal read is queued for return.
  task automatic expect_gnt(input string tag, input bit port, input bit err_exp,
                            input logic [XL-1:0] data, input bit is_read);
    chk({tag, "_gnt"}, {62'h0, p1.gnt, p0.gnt}, port ? 64'h2 : 64'h1);
    chk({tag, "_err"}, {62'h0, p1.err, p0.err}, err_exp ? (port ? 64'h2 : 64'h1) : 64'h0);
    if (is_read && !err_exp) sb.push_back('{port: port, data: data, due: cyc + 2});
  endtask

  task automatic drain(input string tag);
    repeat (4) tick();
    chk({tag, "_drained"}, 64'(sb.size()), 64'h0);
  endtask

  initial begin
    p0.req = 0; p0.we = 0; p0.addr = '0; p0.wdata = '0; p0.size = 2'b10; p0.is_unsigned = 0;
    p1.req = 0; p1.we = 0; p1.addr = '0; p1.wdata = '0; p1.size = 2'b10; p1.is_unsigned = 0;

    // Reset: a pending request must not be granted.
    drive(0, 0, 12'h010, 32'h0, 2'b10, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {62'h0, p1.gnt, p0.gnt}, 64'h0);
    chk("rst_rdEn", 64'(ram_rdEn), 64'h0);
    chk("rst_rvalid", {62'h0, p1.rvalid, p0.rvalid}, 64'h0);
    chk("rst_proto_err", 64'(proto_err), 64'h0);
    drop(0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: single word read on p0
    drive(0, 0, 12'h010, 32'h0, 2'b10, 0);
    @(negedge clk);
    expect_gnt("t1", 0, 0, 32'h12345678, 1);
    chk("t1_rdEn", 64'(ram_rdEn), 64'h1);
    chk("t1_wordEn", {61'h0, ram_byteEn, ram_halfEn, ram_wordEn}, 64'h1);
    chk("t1_addr", 64'(ram_addr), 64'h010);
    tick();
    drop(0);
    drain("t1");

    // 2: continuous requests from both ports alternate, p0 first after reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    drive(0, 0, 12'h020, 32'h0, 2'b10, 0);
    drive(1, 0, 12'h024, 32'h0, 2'b10, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      expect_gnt("t2", i[0], 0, i[0] ? 32'h0BADBEEF : 32'hCAFEF00D, 1);
      tick();
    end
    drop(0);
    drop(1);
    drain("t2");

    // 3: byte store then signed and unsigned byte loads, back to back
    drive(1, 1, 12'h032, 32'h000000A5, 2'b00, 0);
    @(negedge clk);
    expect_gnt("t3_st", 1, 0, 32'h0, 0);
    chk("t3_wrEn", {62'h0, ram_wrEn, ram_rdEn}, 64'h2);
    chk("t3_byteEn", {61'h0, ram_byteEn, ram_halfEn, ram_wordEn}, 64'h4);
    tick();
    drive(1, 0, 12'h032, 32'h0, 2'b00, 0);
    @(negedge clk);
    expect_gnt("t3_lds", 1, 0, 32'hFFFFFFA5, 1);
    tick();
    drive(1, 0, 12'h032, 32'h0, 2'b00, 1);
    @(negedge clk);
    expect_gnt("t3_ldu", 1, 0, 32'h000000A5, 1);
    chk("t3_unsignedEn", 64'(ram_unsignedEn), 64'h1);
    tick();
    drop(1);
    drain("t3");

    // 4: misaligned word and illegal size are rejected without a RAM op
    drive(0, 0, 12'h041, 32'h0, 2'b10, 0);
    @(negedge clk);
    expect_gnt("t4_misal", 0, 1, 32'h0, 1);
    chk("t4_strobes", {62'h0, ram_wrEn, ram_rdEn}, 64'h0);
    tick();
    drop(0);
    drive(1, 1, 12'h044, 32'h0, 2'b11, 0);
    @(negedge clk);
    expect_gnt("t4_size3", 1, 1, 32'h0, 0);
    chk("t4_size3_strobes", {62'h0, ram_wrEn, ram_rdEn}, 64'h0);
    tick();
    drop(1);
    drive(0, 0, 12'h043, 32'h0, 2'b01, 0);
    @(negedge clk);
    expect_gnt("t4_half", 0, 1, 32'h0, 1);
    tick();
    drop(0);
    drain("t4");

    // 5: interleaved reads p0,p1,p0 on consecutive cycles
    drive(0, 0, 12'h010, 32'h0, 2'b10, 0);
    @(negedge clk);
    expect_gnt("t5_a", 0, 0, 32'h12345678, 1);
    tick();
    drop(0);
    drive(1, 0, 12'h024, 32'h0, 2'b10, 0);
    @(negedge clk);
    expect_gnt("t5_b", 1, 0, 32'h0BADBEEF, 1);
    tick();
    drop(1);
    drive(0, 0, 12'h022, 32'h0, 2'b01, 1);
    @(negedge clk);
    expect_gnt("t5_c", 0, 0, 32'h0000CAFE, 1);
    tick();
    drop(0);
    drain("t5");

    // 6: reset with two reads in flight, then an unexpected ram_outEn
    drive(0, 0, 12'h010, 32'h0, 2'b10, 0);
    @(negedge clk);
    expect_gnt("t6_a", 0, 0, 32'h12345678, 1);
    tick();
    drive(0, 0, 12'h020, 32'h0, 2'b10, 0);
    @(negedge clk);
    expect_gnt("t6_b", 0, 0, 32'hCAFEF00D, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    drop(0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t6_no_rvalid", 64'(sb.size()), 64'h0);
    chk("t6_proto_quiet", 64'(proto_err), 64'h0);
    force_oe = 1'b1;
    tick();
    force_oe = 1'b0;
    @(negedge clk);
    chk("t6_proto_set", 64'(proto_err), 64'h1);
    tick();
    @(negedge clk);
    chk("t6_proto_sticky", 64'(proto_err), 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
